// File: rtl/jt49_wrsched_if.sv
// Bundle between the write requesters/PSG side and the jt49 write scheduler.
//  a_*/b_*  : requester A (CPU) and B (music player) valid/ready register writes
//  psg_*    : single adr/data_in/wr port towards jt49
//  level    : FIFO occupancy, busy: scheduler has work in flight
// master = requesters + PSG observer, slave = scheduler.
interface jt49_wrsched_if #(
    parameter int unsigned AW = 2
);
    logic          a_valid;
    logic          a_ready;
    logic [3:0]    a_adr;
    logic [7:0]    a_data;
    logic          b_valid;
    logic          b_ready;
    logic [3:0]    b_adr;
    logic [7:0]    b_data;
    logic [3:0]    psg_adr;
    logic [7:0]    psg_din;
    logic          psg_wr;
    logic [AW:0]   level;
    logic          busy;

    modport master (
        output a_valid, a_adr, a_data, b_valid, b_adr, b_data,
        input  a_ready, b_ready, psg_adr, psg_din, psg_wr, level, busy
    );

    modport slave (
        input  a_valid, a_adr, a_data, b_valid, b_adr, b_data,
        output a_ready, b_ready, psg_adr, psg_din, psg_wr, level, busy
    );
endinterface

// File: rtl/jt49_wrsched.sv
// Write scheduler for the jt49 PSG register port.
// Two requesters are round-robin arbitrated into a 2**AW entry FIFO; entries are
// issued to the PSG one at a time, each write held until a cen edge consumes it,
// followed by GAP idle cen ticks.
//  clk, rst_n : clock, async active-low reset
//  cen        : PSG clock enable (write edge qualifier)
//  flush      : synchronous clear of FIFO, issue FSM, gap and priority
//  bus        : requester handshakes, PSG port, level/busy status (slave side)
module jt49_wrsched #(
    parameter int unsigned AW  = 2,
    parameter int unsigned GAP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           flush,
    jt49_wrsched_if.slave  bus
);
    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned EW    = 12;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned GW    = 4;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_GAPW} state_t;

    state_t          r_state, w_state_nxt;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr, r_level;
    logic [PW-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
    logic [GW-1:0]   r_gap, w_gap_nxt;
    logic [3:0]      r_psg_adr, w_psg_adr_nxt;
    logic [7:0]      r_psg_din, w_psg_din_nxt;
    logic            r_psg_wr, w_psg_wr_nxt;
    logic            r_rr, w_rr_nxt;
    logic            r_busy, w_busy_nxt;
    logic            w_full, w_empty, w_grant_a, w_grant_b, w_push, w_pop;
    logic [EW-1:0]   w_push_data, w_head;

    // FIFO status from registered pointers only; ready never sees the same-edge pop
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Round-robin grant; r_rr=0 favours A, r_rr=1 favours B
    assign w_grant_a = rst_n & ~w_full & ~flush & bus.a_valid & (~bus.b_valid | ~r_rr);
    assign w_grant_b = rst_n & ~w_full & ~flush & bus.b_valid & (~bus.a_valid |  r_rr);
    assign w_push      = w_grant_a | w_grant_b;
    assign w_push_data = w_grant_a ? {bus.a_adr, bus.a_data} : {bus.b_adr, bus.b_data};

    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;
    assign bus.psg_adr = r_psg_adr;
    assign bus.psg_din = r_psg_din;
    assign bus.psg_wr  = r_psg_wr;
    assign bus.level   = r_level;
    assign bus.busy    = r_busy;

    // Issue FSM, FIFO pointers and priority: next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap;
        w_psg_adr_nxt = r_psg_adr;
        w_psg_din_nxt = r_psg_din;
        w_psg_wr_nxt  = r_psg_wr;
        w_pop         = 1'b0;
        if (flush) begin
            w_state_nxt  = S_IDLE;
            w_psg_wr_nxt = 1'b0;
            w_gap_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_psg_adr_nxt = w_head[11:8];
                        w_psg_din_nxt = w_head[7:0];
                        w_psg_wr_nxt  = 1'b1;
                        w_pop         = 1'b1;
                        w_state_nxt   = S_WR;
                    end
                end
                S_WR: begin
                    if (cen) begin
                        w_psg_wr_nxt = 1'b0;
                        w_gap_nxt    = GW'(GAP);
                        w_state_nxt  = (GAP != 0) ? S_GAPW : S_IDLE;
                    end
                end
                S_GAPW: begin
                    if (cen) begin
                        w_gap_nxt = r_gap - GW'(1);
                        if (r_gap <= GW'(1)) begin
                            w_gap_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
        w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
        w_rr_nxt     = r_rr;
        if (w_grant_a) w_rr_nxt = 1'b1;
        if (w_grant_b) w_rr_nxt = 1'b0;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_rr_nxt     = 1'b0;
        end
        w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_busy_nxt  = (w_state_nxt != S_IDLE) | (w_level_nxt != '0);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_psg_adr <= '0;
            r_psg_din <= '0;
            r_psg_wr  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rr      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_psg_adr <= w_psg_adr_nxt;
            r_psg_din <= w_psg_din_nxt;
            r_psg_wr  <= w_psg_wr_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_level   <= w_level_nxt;
            r_rr      <= w_rr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // FIFO storage, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end
endmodule

// File: tb/tb_jt49_wrsched.sv
// Self-checking bench for jt49_wrsched: two instances (GAP=1 and GAP=2) share one
// stimulus stream and are each compared against a queue-based reference model.
module tb_jt49_wrsched;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n, cen, flush;
    always #5 clk = ~clk;

    jt49_wrsched_if #(.AW(AW)) bus0 ();
    jt49_wrsched_if #(.AW(AW)) bus1 ();

    jt49_wrsched #(.AW(AW), .GAP(1)) dut0 (.clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush), .bus(bus0.slave));
    jt49_wrsched #(.AW(AW), .GAP(2)) dut1 (.clk(clk), .rst_n(rst_n), .cen(cen), .flush(flush), .bus(bus1.slave));

    // stimulus copies
    logic       s_av, s_bv;
    logic [3:0] s_aa, s_ba;
    logic [7:0] s_ad, s_bd;

    // observed outputs, indexed by instance
    logic        rdy_a [2], rdy_b [2], o_wr [2], o_busy [2];
    logic [3:0]  o_adr [2];
    logic [7:0]  o_din [2];
    logic [AW:0] o_lvl [2];
    always_comb begin
        rdy_a[0] = bus0.a_ready;  rdy_a[1] = bus1.a_ready;
        rdy_b[0] = bus0.b_ready;  rdy_b[1] = bus1.b_ready;
        o_wr[0]  = bus0.psg_wr;   o_wr[1]  = bus1.psg_wr;
        o_busy[0]= bus0.busy;     o_busy[1]= bus1.busy;
        o_adr[0] = bus0.psg_adr;  o_adr[1] = bus1.psg_adr;
        o_din[0] = bus0.psg_din;  o_din[1] = bus1.psg_din;
        o_lvl[0] = bus0.level;    o_lvl[1] = bus1.level;
    end

    // reference model state
    int          gap_of [2] = '{1, 2};
    logic [11:0] mq [2][$];
    bit          m_hold [2];
    logic [11:0] m_out [2];
    int          m_gap [2];
    bit          m_prefer_b [2];
    // observed PSG write log and the cen tick index of each write
    logic [11:0] wlog [2][$];
    int          wtick [2][$];
    int          cticks [2];
    bit          pre_a [2], pre_b [2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv(input bit av, input logic [3:0] aa, input logic [7:0] ad,
                       input bit bv, input logic [3:0] ba, input logic [7:0] bd,
                       input bit c, input bit f);
        s_av = av; s_aa = aa; s_ad = ad;
        s_bv = bv; s_ba = ba; s_bd = bd;
        bus0.a_valid = av; bus0.a_adr = aa; bus0.a_data = ad;
        bus0.b_valid = bv; bus0.b_adr = ba; bus0.b_data = bd;
        bus1.a_valid = av; bus1.a_adr = aa; bus1.a_data = ad;
        bus1.b_valid = bv; bus1.b_adr = ba; bus1.b_data = bd;
        cen = c; flush = f;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_hold[k] = 1'b0; m_out[k] = '0; m_gap[k] = 0; m_prefer_b[k] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_wr%0d", pfx, k), int'(o_wr[k]), int'(m_hold[k]));
            check($sformatf("%s_adr%0d", pfx, k), int'(o_adr[k]), int'(m_out[k][11:8]));
            check($sformatf("%s_din%0d", pfx, k), int'(o_din[k]), int'(m_out[k][7:0]));
            check($sformatf("%s_lvl%0d", pfx, k), int'(o_lvl[k]), mq[k].size());
            check($sformatf("%s_busy%0d", pfx, k), int'(o_busy[k]),
                  int'(m_hold[k] || m_gap[k] > 0 || mq[k].size() > 0));
        end
    endtask

    // one clock: inputs were driven after the previous negedge
    task automatic cycle();
        bit ga [2], gb [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit room;
            room  = !flush && (mq[k].size() < DEPTH);
            ga[k] = room && s_av && (!s_bv || !m_prefer_b[k]);
            gb[k] = room && s_bv && (!s_av ||  m_prefer_b[k]);
            check($sformatf("a_ready%0d", k), int'(rdy_a[k]), int'(ga[k]));
            check($sformatf("b_ready%0d", k), int'(rdy_b[k]), int'(gb[k]));
            pre_a[k] = rdy_a[k]; pre_b[k] = rdy_b[k];
            if (o_wr[k] && cen && !flush) begin
                wlog[k].push_back({o_adr[k], o_din[k]});
                wtick[k].push_back(cticks[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cen) cticks[k]++;
            if (flush) begin
                mq[k].delete();
                m_hold[k] = 1'b0; m_gap[k] = 0; m_prefer_b[k] = 1'b0;
            end else begin
                if (m_hold[k]) begin
                    if (cen) begin m_hold[k] = 1'b0; m_gap[k] = gap_of[k]; end
                end else if (m_gap[k] > 0) begin
                    if (cen) m_gap[k]--;
                end else if (mq[k].size() > 0) begin
                    m_hold[k] = 1'b1;
                    m_out[k]  = mq[k].pop_front();
                end
                if (ga[k]) begin mq[k].push_back({s_aa, s_ad}); m_prefer_b[k] = 1'b1; end
                if (gb[k]) begin mq[k].push_back({s_ba, s_bd}); m_prefer_b[k] = 1'b0; end
            end
        end
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_a_ready%0d", k), int'(rdy_a[k]), 0);
            check($sformatf("rst_b_ready%0d", k), int'(rdy_b[k]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        for (int k = 0; k < 2; k++) begin
            wlog[k].delete(); wtick[k].delete(); cticks[k] = 0;
        end
    endtask

    initial begin
        int wcount;
        rst_n = 1'b0;
        model_reset();
        clear_log();
        drv(1'b1, 4'h5, 8'hA5, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        // 1: reset with a_valid held, then first transaction latency
        async_reset();
        cycle();
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        check("t1_no_wr_yet", int'(o_wr[0]), 0);
        cycle();
        check("t1_wr_high", int'(o_wr[0]), 1);
        check("t1_adr", int'(o_adr[0]), 5);
        check("t1_din", int'(o_din[0]), 8'hA5);
        cycle();
        check("t1_wr_low", int'(o_wr[0]), 0);
        for (int i = 0; i < 4; i++) cycle();

        // 2: round-robin, both valid with cen=0
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 4'(i), 8'(8'h10 + i), 1'b1, 4'(i + 8), 8'(8'h80 + i), 1'b0, 1'b0);
            cycle();
            check("t2_grant_a", int'(pre_a[0]), int'(i % 2 == 0));
            check("t2_grant_b", int'(pre_b[0]), int'(i % 2 == 1));
        end
        check("t2_level", int'(o_lvl[0]), 3);
        cycle();
        check("t2_full", int'(o_lvl[0]), 4);
        cycle();
        check("t2_no_ready_a", int'(pre_a[0]), 0);
        check("t2_no_ready_b", int'(pre_b[0]), 0);

        // 3: fill, reject at full, one cen edge consumes one write
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 10 && o_lvl[0] != 3'(DEPTH); i++) begin
            drv(1'b1, 4'(i), 8'($urandom), 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            cycle();
        end
        check("t3_level_full", int'(o_lvl[0]), DEPTH);
        cycle();
        check("t3_rejected", int'(pre_a[0]), 0);
        check("t3_level_held", int'(o_lvl[0]), DEPTH);
        clear_log();
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        cycle();
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        cycle();
        check("t3_one_write", wlog[0].size(), 1);

        // 4: gap spacing with cen every 4th clk
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        cycle();
        drv(1'b1, 4'h7, 8'h38, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0); cycle();
        drv(1'b1, 4'h8, 8'h0F, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0); cycle();
        drv(1'b1, 4'h0, 8'h55, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0); cycle();
        clear_log();
        for (int i = 0; i < 80; i++) begin
            drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, (i % 4) == 3, 1'b0);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t4_count%0d", k), wlog[k].size(), 3);
            if (wlog[k].size() == 3) begin
                check($sformatf("t4_w0_%0d", k), int'(wlog[k][0]), 12'h738);
                check($sformatf("t4_w1_%0d", k), int'(wlog[k][1]), 12'h80F);
                check($sformatf("t4_w2_%0d", k), int'(wlog[k][2]), 12'h055);
                check($sformatf("t4_space1_%0d", k), wtick[k][1] - wtick[k][0], gap_of[k] + 1);
                check($sformatf("t4_space2_%0d", k), wtick[k][2] - wtick[k][1], gap_of[k] + 1);
            end
        end

        // 5: flush while a write is held, with a competing a_valid
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 4'(i + 1), 8'($urandom), 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            cycle();
        end
        check("t5_queued", int'(o_lvl[0]), 3);
        check("t5_in_wr", int'(o_wr[0]), 1);
        drv(1'b1, 4'hC, 8'hCC, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        cycle();
        check("t5_not_accepted", int'(pre_a[0]), 0);
        check("t5_wr_abort", int'(o_wr[0]), 0);
        check("t5_level", int'(o_lvl[0]), 0);
        check("t5_busy", int'(o_busy[0]), 0);

        // 6: same-edge push/pop at level 2, then reset in mid-operation
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 4'(i + 2), 8'($urandom), 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            cycle();
        end
        drv(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        cycle();
        cycle();
        check("t6_level_before", int'(o_lvl[0]), 2);
        drv(1'b0, 4'h0, 8'h00, 1'b1, 4'hE, 8'hEE, 1'b0, 1'b0);
        cycle();
        check("t6_level_same", int'(o_lvl[0]), 2);
        check("t6_wr_again", int'(o_wr[0]), 1);
        #3;
        async_reset();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drv($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom),
                $urandom_range(0, 2) != 0, 4'($urandom), 8'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
            cycle();
            if ($urandom_range(0, 300) == 0) begin
                #2;
                async_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
